// File: rtl/btn_ctrl_pkg.sv
// Shared constants and the status-word layout for the button controller.
package btn_ctrl_pkg;

  localparam int unsigned NUM_BTN      = 5;
  localparam logic [31:0] BTN_ADDR_DEF = 32'hFFFF_F078;
  localparam int unsigned BTN_LVL_LSB  = 0;
  localparam int unsigned BTN_CNT_LSB  = 8;
  localparam int unsigned BTN_CNT_W    = 4;

  // Field order matches the bus word: pc[i] lands at bit 8+4i.
  typedef struct packed {
    logic [3:0]                          rsvd_hi;
    logic [NUM_BTN-1:0][BTN_CNT_W-1:0]   cnt;
    logic [2:0]                          rsvd_lo;
    logic [NUM_BTN-1:0]                  lvl;
  } btn_word_t;

endpackage

// File: rtl/btn_debounce.sv
// One button bit: two-flop synchroniser, stability counter, accepted level
// and a one-cycle pulse in the cycle after the level goes 0->1.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 25000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic lvl_o,
  output logic rise_o
);

  localparam int unsigned     CW      = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1_q, s2_q;
  logic          lvl_q, lvl_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d  = cnt_q + CW'(1);
    lvl_d  = lvl_q;
    rise_d = 1'b0;
    if (s2_q == lvl_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d  = '0;
      lvl_d  = s2_q;
      rise_d = s2_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      cnt_q  <= '0;
      lvl_q  <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      s1_q   <= btn_i;
      s2_q   <= s1_q;
      cnt_q  <= cnt_d;
      lvl_q  <= lvl_d;
      rise_q <= rise_d;
    end
  end

  assign lvl_o  = lvl_q;
  assign rise_o = rise_q;

endmodule

// File: rtl/btn_ctrl.sv
// Five debounced push-buttons behind one read-only status word.
// Define BTN_PRESS_CNT_EN to build the per-button 4-bit press counters.
module btn_ctrl
  import btn_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 25000,
  parameter logic [31:0] BTN_ADDR        = BTN_ADDR_DEF
) (
  input  logic                clk_from_bg,
  input  logic                rst_from_bg,
  input  logic [NUM_BTN-1:0]  btn_from_soc,
  input  logic [31:0]         addr_from_bg,
  output logic [31:0]         rdata_to_bg
);

  logic [NUM_BTN-1:0]                lvl;
  logic [NUM_BTN-1:0]                rise;
  logic [NUM_BTN-1:0][BTN_CNT_W-1:0] pc;
  btn_word_t                         word;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk_i (clk_from_bg),
      .rst_i (rst_from_bg),
      .btn_i (btn_from_soc[i]),
      .lvl_o (lvl[i]),
      .rise_o(rise[i])
    );
  end

`ifdef BTN_PRESS_CNT_EN
  logic [NUM_BTN-1:0][BTN_CNT_W-1:0] pc_q, pc_d;

  // Counters wrap naturally; only reset clears them.
  always_comb begin
    pc_d = pc_q;
    for (int i = 0; i < NUM_BTN; i++)
      if (rise[i]) pc_d[i] = pc_q[i] + BTN_CNT_W'(1);
  end

  always_ff @(posedge clk_from_bg) begin
    if (rst_from_bg) pc_q <= '0;
    else             pc_q <= pc_d;
  end

  assign pc = pc_q;
`else
  logic unused_rise;
  assign unused_rise = ^rise;
  assign pc          = '0;
`endif

  always_comb begin
    word     = '0;
    word.lvl = lvl;
    word.cnt = pc;
  end

  assign rdata_to_bg = (addr_from_bg == BTN_ADDR) ? word : 32'h0;

endmodule
